// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, the hex glyph table
// and the decode result type used by both the encoder and capture sides.
package seg7_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef logic [6:0] seg_pattern_t;

    localparam seg_pattern_t SEG_BLANK = 7'b1111111;

    // Active-low glyphs, index = nibble, bit order {g,f,e,d,c,b,a}
    localparam seg_pattern_t SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] nibble;
    } decode_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Multiplexed display bus plus the decoded per-digit results of the capture block.
interface seg7_capture_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    logic [7:0]              seg_n;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [4*NUM_DIGITS-1:0] hex_val;
    logic [NUM_DIGITS-1:0]   dot_val;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    pattern_err;
    logic                    frame_done;

    modport master (
        output seg_n, dig_sel,
        input  hex_val, dot_val, digit_valid, pattern_err, frame_done
    );

    modport slave (
        input  seg_n, dig_sel,
        output hex_val, dot_val, digit_valid, pattern_err, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of a 7-segment glyph into its hex nibble.
module seg7_decode
    import seg7_pkg::*;
(
    input  seg_pattern_t pattern_i,
    output decode_t      decode_o
);

    always_comb begin
        decode_o       = '0;
        decode_o.blank = (pattern_i == SEG_BLANK);
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern_i == SEG_TABLE[i]) begin
                decode_o.valid  = 1'b1;
                decode_o.nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed active-low display bus, waits for a stable pattern,
// and stores the decoded nibble/dot per digit with frame completion tracking.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    seg7_capture_if.slave bus
);

    localparam int unsigned SW    = NUM_DIGITS + 8;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SW-1:0]           s_q, sample_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    commit_q, commit_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dot_q, dot_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [NUM_DIGITS-1:0]   last_q, last_d;
    logic                    err_q, err_d;
    logic                    frame_q, frame_d;

    logic [NUM_DIGITS-1:0]   sel_w;
    logic [7:0]              seg_w;
    logic                    sel_onehot;
    logic                    frame_wrap;
    decode_t                 dec;

    assign sel_w      = s_q[SW-1:8];
    assign seg_w      = s_q[7:0];
    assign sel_onehot = (sel_w != '0) && ((sel_w & (sel_w - NUM_DIGITS'(1))) == '0);
    assign frame_wrap = (seen_q == '1);

    seg7_decode u_decode (
        .pattern_i (seg_w[SEG_G:SEG_A]),
        .decode_o  (dec)
    );

    // Commit is registered one cycle after the counter reaches its top value;
    // s_q still holds the stable pattern on that cycle.
    always_comb begin
        sample_d = {bus.dig_sel, bus.seg_n};
        if ((sample_d != s_q) || !sel_onehot) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        commit_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end

    always_comb begin
        hex_d   = hex_q;
        dot_d   = dot_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;
        frame_d = frame_wrap;
        seen_d  = frame_wrap ? '0 : seen_q;
        if (commit_q) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (sel_w[i]) begin
                    if (dec.valid) begin
                        hex_d[4*i +: 4] = dec.nibble;
                        dot_d[i]        = ~seg_w[SEG_DP];
                        valid_d[i]      = 1'b1;
                    end else begin
                        valid_d[i] = 1'b0;
                        if (dec.blank) dot_d[i] = ~seg_w[SEG_DP];
                    end
                end
            end
            err_d = !dec.valid && !dec.blank;
            // On a wrap cycle only a different digit seeds the new frame.
            if (!frame_wrap) begin
                seen_d = seen_q | sel_w;
            end else if (sel_w != last_q) begin
                seen_d = sel_w;
            end
            last_d = sel_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= '0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
            hex_q    <= '0;
            dot_q    <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            last_q   <= '0;
            err_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            s_q      <= sample_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            hex_q    <= hex_d;
            dot_q    <= dot_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            last_q   <= last_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.hex_val     = hex_q;
    assign bus.dot_val     = dot_q;
    assign bus.digit_valid = valid_q;
    assign bus.pattern_err = err_q;
    assign bus.frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with a sample-history reference model.
module tb_seg7_capture;

    localparam int ND = 6;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_capture_if #(.NUM_DIGITS(ND)) bus ();

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_seen = 0;
    int frame_seen = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a commit happens when the SC most recent samples are
    // identical with a one-hot select and the sample before them differed.
    logic [ND+7:0]  hist [$];
    logic [4*ND-1:0] m_hex;
    logic [ND-1:0]  m_dot, m_valid, m_seen, m_last;
    logic           m_err, m_frame;

    function automatic void mdec(input logic [6:0] p, output logic ok, output logic [3:0] nib);
        ok = 1'b0;
        nib = 4'h0;
        for (int k = 0; k < 16; k++) if (pat[k] == p) begin ok = 1'b1; nib = 4'(k); end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            hist.push_back('0);
            m_hex = '0; m_dot = '0; m_valid = '0; m_seen = '0; m_last = '0;
            m_err = 1'b0; m_frame = 1'b0;
        end else begin
            logic commit, wrap, ok;
            logic [ND+7:0] v;
            logic [ND-1:0] sel;
            logic [3:0] nib;
            int n;
            commit = 1'b0;
            sel = '0;
            v = '0;
            n = hist.size();
            wrap = (m_seen == '1);
            m_frame = wrap;
            m_err = 1'b0;
            if (wrap) m_seen = '0;
            if (n >= SC + 1) begin
                v = hist[n-1];
                commit = 1'b1;
                for (int j = 1; j <= SC; j++) if (hist[n-j] != v) commit = 1'b0;
                if (hist[n-SC-1] == v) commit = 1'b0;
                sel = v[ND+7:8];
                if ($countones(sel) != 1) commit = 1'b0;
            end
            if (commit) begin
                mdec(v[6:0], ok, nib);
                for (int d = 0; d < ND; d++) if (sel[d]) begin
                    if (ok) begin
                        m_hex[4*d +: 4] = nib;
                        m_dot[d] = ~v[7];
                        m_valid[d] = 1'b1;
                    end else begin
                        m_valid[d] = 1'b0;
                        if (v[6:0] == 7'h7F) m_dot[d] = ~v[7];
                    end
                end
                m_err = !ok && (v[6:0] != 7'h7F);
                if (!wrap) m_seen = m_seen | sel;
                else if (sel != m_last) m_seen = sel;
                m_last = sel;
            end
            hist.push_back({bus.dig_sel, bus.seg_n});
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("hex_val", 32'(bus.hex_val), 32'(m_hex));
            chk("dot_val", 32'(bus.dot_val), 32'(m_dot));
            chk("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
            chk("pattern_err", 32'(bus.pattern_err), 32'(m_err));
            chk("frame_done", 32'(bus.frame_done), 32'(m_frame));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pattern_err) err_seen++;
            if (bus.frame_done) frame_seen++;
        end
    end

    task automatic hold(input logic [ND-1:0] sel, input logic [7:0] seg, input int n);
        bus.dig_sel = sel;
        bus.seg_n = seg;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int eb, fb;
        bus.dig_sel = '0;
        bus.seg_n = 8'hFF;
        repeat (2) @(negedge clk);
        chk("rst_hex", 32'(bus.hex_val), 32'h0);
        chk("rst_valid", 32'(bus.digit_valid), 32'h0);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Legal decode with latency pin on digit 0
        bus.dig_sel = 6'b000001;
        bus.seg_n = 8'b1_0100100;
        repeat (4) @(negedge clk);
        chk("lat_before", 32'(bus.digit_valid[0]), 32'h0);
        @(negedge clk);
        chk("lat_valid0", 32'(bus.digit_valid[0]), 32'h1);
        chk("lat_hex0", 32'(bus.hex_val[3:0]), 32'h2);
        chk("lat_dot0", 32'(bus.dot_val[0]), 32'h0);
        @(negedge clk);
        hold('0, 8'hFF, 2);

        // Dot lit, all 16 glyphs on digit 3
        for (int n = 0; n < 16; n++) begin
            hold(6'b001000, {1'b0, pat[n]}, 4);
            if (n > 0) chk("sweep_hex3", 32'(bus.hex_val[15:12]), 32'(n - 1));
        end
        hold('0, 8'hFF, 2);
        chk("sweep_hexF", 32'(bus.hex_val[15:12]), 32'hF);
        chk("sweep_dot3", 32'(bus.dot_val[3]), 32'h1);

        // Glitching pattern on digit 2 never stabilises
        for (int r = 0; r < 4; r++)
            hold(6'b000100, (r % 2 == 0) ? {1'b1, pat[3]} : {1'b1, pat[5]}, 3);
        hold('0, 8'hFF, 2);
        chk("glitch_valid2", 32'(bus.digit_valid[2]), 32'h0);
        chk("glitch_hex2", 32'(bus.hex_val[11:8]), 32'h0);

        // Illegal, blank and non-one-hot on digit 1
        hold(6'b000010, {1'b1, pat[7]}, 6);
        #1 eb = err_seen;
        hold(6'b000010, 8'b1_1111110, 6);
        #1 chk("illegal_err", 32'(err_seen - eb), 32'h1);
        chk("illegal_valid1", 32'(bus.digit_valid[1]), 32'h0);
        chk("illegal_hex1", 32'(bus.hex_val[7:4]), 32'h7);
        hold(6'b000010, 8'hFF, 6);
        #1 chk("blank_err", 32'(err_seen - eb), 32'h1);
        chk("blank_valid1", 32'(bus.digit_valid[1]), 32'h0);
        hold(6'b000010, 8'h7F, 6);
        chk("blank_dot1", 32'(bus.dot_val[1]), 32'h1);
        hold(6'b000011, {1'b1, pat[0]}, 8);
        chk("multi_hex", 32'(bus.hex_val[7:0]), 32'h72);

        // Asynchronous reset with stability count at 2
        hold(6'b000100, {1'b1, pat[3]}, 3);
        #2 rst = 1'b1;
        #1 chk("arst_hex", 32'(bus.hex_val), 32'h0);
        chk("arst_dot", 32'(bus.dot_val), 32'h0);
        chk("arst_valid", 32'(bus.digit_valid), 32'h0);
        chk("arst_pulses", 32'({bus.pattern_err, bus.frame_done}), 32'h0);
        bus.dig_sel = '0;
        bus.seg_n = 8'hFF;
        eb = err_seen;
        fb = frame_seen;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        #1 chk("post_rst_pulses", 32'((err_seen - eb) + (frame_seen - fb)), 32'h0);
        chk("post_rst_valid", 32'(bus.digit_valid), 32'h0);

        // Frame completion
        fb = frame_seen;
        for (int d = 0; d < ND; d++) hold(6'(1 << d), {1'b1, pat[d + 1]}, 5);
        chk("frame_hex", 32'(bus.hex_val), 32'h654321);
        chk("frame_early", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        chk("frame_pulse", 32'(bus.frame_done), 32'h1);
        hold(6'b000001, {1'b1, pat[10]}, 5);
        hold('0, 8'hFF, 2);
        hold(6'b000001, {1'b1, pat[11]}, 5);
        for (int d = 1; d < ND; d++) hold(6'(1 << d), {1'b1, pat[d + 1]}, 5);
        hold('0, 8'hFF, 4);
        #1 chk("frame_count", 32'(frame_seen - fb), 32'h2);
        chk("frame_hex0", 32'(bus.hex_val[3:0]), 32'hB);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Observes a multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit select).
- Decodes each stable pattern back to a 4-bit hex value and dot flag, stored per digit.
- Used as an on-chip loopback checker for display outputs (e.g. the multiplier result path) and as a bench monitor.

Parameters:
- NUM_DIGITS, 6, number of display digits and width of dig_sel.
- STABLE_CYCLES, 4, consecutive identical samples required before a commit (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- seg_n  in  8  active-low segments: bit0=a(top), 1=b, 2=c, 3=d, 4=e, 5=f, 6=g(middle), 7=dot (low means dot lit).
- dig_sel  in  NUM_DIGITS  one-hot, active-high; selects the digit currently driven.
- hex_val  out  4*NUM_DIGITS  decoded nibble per digit; digit i occupies bits [4i+3:4i].
- dot_val  out  NUM_DIGITS  decoded dot per digit.
- digit_valid  out  NUM_DIGITS  1 when the last commit for that digit was a legal hex pattern.
- pattern_err  out  1  one-cycle pulse on commit of an illegal non-blank pattern.
- frame_done  out  1  one-cycle pulse when every digit has committed since the last pulse.

Behaviour:
- Reset: all outputs 0, sample register 0, stability counter 0, seen-mask 0. Reset is asynchronous and may assert at any time, including mid-stability count; all state clears.
- Sampling: {dig_sel, seg_n} registered every cycle into s.
  - New sample differs from s: cnt <= 0.
  - Otherwise: cnt increments, saturating at STABLE_CYCLES-1.
- Commit: happens on the cycle cnt transitions to STABLE_CYCLES-1. Exactly one commit per stable period; held input does not recommit.
  - Latency: inputs first present at edge k and held give updated outputs after edge k+STABLE_CYCLES.
- dig_sel check: if dig_sel in s is not one-hot (zero or multiple bits), cnt is forced to 0 and no commit occurs. No error flag is raised (blanking gap).
- Decode of seg_n[6:0]. Legal patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Commit to digit i by result:
  - Legal: hex_val[i] <= nibble, dot_val[i] <= ~seg_n[7], digit_valid[i] <= 1.
  - Blank (1111111): digit_valid[i] <= 0, dot_val[i] <= ~seg_n[7], hex_val[i] unchanged, no error.
  - Other patterns: digit_valid[i] <= 0, hex_val[i] unchanged, pattern_err pulses 1 cycle.
- Frame: on every commit (legal, blank or illegal), seen[i] <= 1.
  - If seen becomes all-ones: frame_done pulses the following cycle and seen <= 0.
  - A commit coinciding with the clear is counted in the new frame only if it is a different digit from the completing one (the completing commit belongs to the old frame).
- Recommitting the same digit within a frame overwrites its value and does not advance the frame.

Decomposition:
- Shared package seg7_pkg:
  - segment bit-index constants (SEG_A..SEG_G, SEG_DP);
  - SEG_BLANK constant;
  - the 16-entry pattern table as a localparam array;
  - typedef seg_pattern_t (logic [6:0]);
  - typedef decode_t {valid, blank, nibble}.
  - The forward encoder and this block share the table.
- Sub-module seg7_decode: combinational, seg_pattern_t in, decode_t out.
- seg7_capture holds the sampling register, stability counter, per-digit storage and frame logic.

Test Plan:
- Reset: assert rst mid-run with cnt=2 -> all outputs 0 immediately, no pulses after release.
- Legal decode: dig_sel=000001, seg_n=8'b1_0100100 held 6 cycles -> after edge k+4, hex_val[3:0]=2, dot_val[0]=0, digit_valid[0]=1; no second commit.
- Dot, all nibbles: sweep digit 3 through all 16 patterns with seg_n[7]=0, each held 4 cycles -> hex_val[15:12] follows 0..F, dot_val[3]=1.
- Glitch rejection: pattern toggles every 3 cycles with STABLE_CYCLES=4 -> no commit, outputs unchanged.
- Illegal/blank/non-one-hot:
  - seg_n=8'b1_1111110 on digit 1 -> pattern_err pulses once, digit_valid[1]=0, hex_val[7:4] kept.
  - 1111111 -> no err, digit_valid[1]=0.
  - dig_sel=000011 -> no commit.
- Frame: scan digits 0..5 legally -> frame_done single pulse one cycle after digit 5 commits. Rescan digit 0 twice then 1..5 -> exactly one further pulse.
